iob_native_arb2: RTL and testbench

IOB_NATIVE_ARB2 -- requirements
Module: iob_native_arb2

---
 rtl/iob_native_arb2.sv | 142 ++++++++++++++
 tb/tb_iob_native_arb2.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_native_arb2.sv
// Two-master round-robin arbiter in front of one native-interface slave.
// Responses pass through combinationally; a per-grant watchdog answers ERR_DATA on slave silence.
module iob_native_arb2 #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_ready,

    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_ready,

    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic                s_ready,

    output logic [1:0]          grant,
    output logic                timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ptr_q, ptr_d;      // 1: m1 wins a tie
    logic             terr_q, terr_d;

    logic             owner_m1;
    logic             owner_valid;
    logic             pick_m1;
    logic             done;
    logic             timeout_hit;
    logic [DATA_W-1:0] resp_data;

    assign owner_m1    = grant_q[1];
    assign owner_valid = owner_m1 ? m1_valid : m0_valid;
    assign timeout_hit = (cnt_q == CNT_LAST) && !s_ready;
    assign resp_data   = timeout_hit ? ERR_DATA : s_rdata;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        terr_d   = terr_q;
        pick_m1  = 1'b0;
        done     = 1'b0;
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m1_ready = 1'b0;
        m0_rdata = '0;
        m1_rdata = '0;

        unique case (state_q)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    pick_m1 = m1_valid && (!m0_valid || ptr_q);
                    grant_d = pick_m1 ? 2'b10 : 2'b01;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_addr  = owner_m1 ? m1_addr  : m0_addr;
                s_wdata = owner_m1 ? m1_wdata : m0_wdata;
                s_wstrb = owner_m1 ? m1_wstrb : m0_wstrb;
                if (!owner_valid) begin
                    // Owner withdrew: abandon quietly, fairness pointer untouched.
                    state_d = IDLE;
                    grant_d = '0;
                end else begin
                    s_valid = !timeout_hit;
                    done    = s_ready || timeout_hit;
                    if (owner_m1) begin
                        m1_rdata = resp_data;
                    end else begin
                        m0_rdata = resp_data;
                    end
                    if (done) begin
                        state_d = IDLE;
                        grant_d = '0;
                        ptr_d   = !owner_m1;
                        if (timeout_hit) begin
                            terr_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
        endcase

        m0_ready = done && !owner_m1 && !rst;
        m1_ready = done &&  owner_m1 && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            terr_q  <= terr_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_iob_native_arb2.sv
// Scoreboard bench for iob_native_arb2: random request rounds against a
// transaction-level arbitration model, plus directed timeout and reset cases.
module tb_iob_native_arb2;

    localparam int          TO  = 16;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk, rst;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        s_valid, s_ready, timeout_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;

    iob_native_arb2 #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TO),
        .ERR_DATA(ERR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_valid   (m0_valid),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_rdata   (m0_rdata),
        .m0_ready   (m0_ready),
        .m1_valid   (m1_valid),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_rdata   (m1_rdata),
        .m1_ready   (m1_ready),
        .s_valid    (s_valid),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_rdata    (s_rdata),
        .s_ready    (s_ready),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          d;       // BUSY cycle index at which the slave answers
        logic [31:0] sdata;
        int          start;   // extra cycles before the master raises valid
    } job_t;

    typedef struct {
        logic [1:0]  grant;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } gexp_t;

    typedef struct {
        logic [31:0] rdata;
        bit          to;
        int          k;
    } rexp_t;

    typedef struct {
        int          d;
        logic [31:0] data;
    } splan_t;

    job_t   q0[$], q1[$];
    gexp_t  gq[$];
    rexp_t  eq0[$], eq1[$];
    splan_t sp[$];

    int checks = 0;
    int errors = 0;
    bit busy0 = 0, busy1 = 0, slave_late = 0;
    int ptr = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic job_t mk_job(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                                    input int d, input logic [31:0] sd, input int st);
        job_t j;
        j.addr = a; j.wdata = w; j.wstrb = s; j.d = d; j.sdata = sd; j.start = st;
        return j;
    endfunction

    function automatic job_t rnd_job();
        int d;
        if ($urandom_range(0, 6) == 0) d = int'($urandom_range(TO - 2, TO + 2));
        else d = int'($urandom_range(0, 5));
        return mk_job($urandom, $urandom, 4'($urandom_range(0, 15)), d, $urandom, 0);
    endfunction

    task automatic wait_ready(input int m);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rst) return;
            if ((m == 0) ? m0_ready : m1_ready) return;
        end
        checks++;
        errors++;
        $display("FAIL m%0d_wait: got no ready in 300 cycles expected a pulse", m);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy0 && !busy1 && grant == 2'b00 &&
                eq0.size() == 0 && eq1.size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: got busy after 500 cycles expected idle");
    endtask

    // Model: a lone requester wins; a same-cycle tie goes to ptr; ptr then points away from the served master.
    task automatic run_round(input bit u0, input bit u1, input job_t j0, input job_t j1);
        int    order[$];
        int    first;
        job_t  j;
        rexp_t r;
        @(negedge clk);
        if (u0 && u1) begin
            if (j0.start < j1.start) first = 0;
            else if (j1.start < j0.start) first = 1;
            else first = ptr;
            order = '{first, 1 - first};
        end else begin
            order = '{u0 ? 0 : 1};
        end
        foreach (order[i]) begin
            j = (order[i] == 0) ? j0 : j1;
            gq.push_back('{grant: (order[i] == 0) ? 2'b01 : 2'b10, addr: j.addr, wdata: j.wdata, wstrb: j.wstrb});
            sp.push_back('{d: j.d, data: j.sdata});
            r.to    = (j.d > TO - 1);
            r.k     = r.to ? TO - 1 : j.d;
            r.rdata = r.to ? ERR : j.sdata;
            if (order[i] == 0) eq0.push_back(r);
            else eq1.push_back(r);
            ptr = 1 - order[i];
        end
        if (u0) q0.push_back(j0);
        if (u1) q1.push_back(j1);
        wait_idle();
    endtask

    initial begin : drv0
        job_t j;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        forever begin
            @(posedge clk); #1;
            if (q0.size() != 0) begin
                j = q0.pop_front();
                busy0 = 1;
                repeat (j.start) begin @(posedge clk); #1; end
                m0_addr = j.addr; m0_wdata = j.wdata; m0_wstrb = j.wstrb; m0_valid = 1;
                wait_ready(0);
                @(posedge clk); #1;
                m0_valid = 0;
                busy0 = 0;
            end
        end
    end

    initial begin : drv1
        job_t j;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        forever begin
            @(posedge clk); #1;
            if (q1.size() != 0) begin
                j = q1.pop_front();
                busy1 = 1;
                repeat (j.start) begin @(posedge clk); #1; end
                m1_addr = j.addr; m1_wdata = j.wdata; m1_wstrb = j.wstrb; m1_valid = 1;
                wait_ready(1);
                @(posedge clk); #1;
                m1_valid = 0;
                busy1 = 0;
            end
        end
    end

    initial begin : slv
        splan_t cur;
        int     sk;
        bit     was_busy;
        s_ready = 0; s_rdata = 0; sk = 0; was_busy = 0;
        cur = '{d: 1000, data: 32'h0};
        forever begin
            @(posedge clk); #2;
            if (grant != 2'b00) begin
                if (!was_busy) begin
                    sk = 0;
                    if (sp.size() != 0) cur = sp.pop_front();
                    else cur = '{d: 1000, data: 32'h0};
                end else begin
                    sk++;
                end
                s_ready = (sk == cur.d);
                s_rdata = cur.data;
            end else begin
                s_ready = slave_late;
                s_rdata = $urandom;
            end
            was_busy = (grant != 2'b00);
        end
    end

    initial begin : mon
        logic [1:0] prev_g;
        int         bk;
        bit         just_done, terr_exp, terr_set, idle_ok;
        gexp_t      g;
        rexp_t      e;
        prev_g = 0; bk = 0; just_done = 0; terr_exp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_g = 0; bk = 0; just_done = 0; terr_exp = 0;
            end else begin
                terr_set = 0;
                chk("timeout_err", 64'(timeout_err), 64'(terr_exp));
                if (just_done) chk("idle_gap_grant", 64'(grant), 64'(2'b00));
                just_done = 0;
                if (grant != 2'b00) begin
                    if (prev_g == 2'b00) begin
                        bk = 0;
                        if (gq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL grant: got %b expected 00 with nothing pending", grant);
                        end else begin
                            g = gq.pop_front();
                            chk("grant", 64'(grant), 64'(g.grant));
                            chk("s_addr", 64'(s_addr), 64'(g.addr));
                            chk("s_wdata", 64'(s_wdata), 64'(g.wdata));
                            chk("s_wstrb", 64'(s_wstrb), 64'(g.wstrb));
                            chk("s_valid_start", 64'(s_valid), 64'(1));
                        end
                    end else begin
                        bk++;
                    end
                end else begin
                    idle_ok = !s_valid && s_addr == 0 && s_wdata == 0 && s_wstrb == 0 &&
                              m0_rdata == 0 && m1_rdata == 0 && !m0_ready && !m1_ready;
                    chk("idle_outputs_quiet", 64'(idle_ok), 64'(1));
                end
                if (m0_ready) begin
                    if (eq0.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL m0_ready: got pulse expected none");
                    end else begin
                        e = eq0.pop_front();
                        chk("m0_rdata", 64'(m0_rdata), 64'(e.rdata));
                        chk("m0_done_cycle", 64'(bk), 64'(e.k));
                        chk("m0_owner", 64'(grant), 64'(2'b01));
                        chk("m0_s_valid_at_done", 64'(s_valid), 64'(!e.to));
                        terr_set = terr_set | e.to;
                    end
                    just_done = 1;
                end
                if (m1_ready) begin
                    if (eq1.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL m1_ready: got pulse expected none");
                    end else begin
                        e = eq1.pop_front();
                        chk("m1_rdata", 64'(m1_rdata), 64'(e.rdata));
                        chk("m1_done_cycle", 64'(bk), 64'(e.k));
                        chk("m1_owner", 64'(grant), 64'(2'b10));
                        chk("m1_s_valid_at_done", 64'(s_valid), 64'(!e.to));
                        terr_set = terr_set | e.to;
                    end
                    just_done = 1;
                end
                if (terr_set) terr_exp = 1;
                prev_g = grant;
            end
        end
    end

    initial begin : main
        job_t       nojob, j0, j1;
        logic [1:0] sel;
        bit         seen;
        nojob = mk_job(0, 0, 0, 0, 0, 0);
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'(2'b00));
        chk("rst_s_valid", 64'(s_valid), 64'(0));
        chk("rst_ready", 64'({m0_ready, m1_ready}), 64'(0));
        chk("rst_rdata", 64'(m0_rdata | m1_rdata), 64'(0));
        chk("rst_timeout_err", 64'(timeout_err), 64'(0));
        @(posedge clk); #1;
        rst = 0;

        // Simultaneous requests after reset, twice: grants alternate 01,10,01,10.
        run_round(1, 1, mk_job(32'h200, 32'h0, 4'h0, 1, 32'h1111_0000, 0),
                        mk_job(32'h300, 32'h5555_AAAA, 4'h3, 2, 32'h2222_0000, 0));
        run_round(1, 1, mk_job(32'h204, 32'h0, 4'h0, 0, 32'h3333_0000, 0),
                        mk_job(32'h304, 32'h6666_BBBB, 4'hC, 4, 32'h4444_0000, 0));
        run_round(1, 0, mk_job(32'h100, 32'h0, 4'h0, 3, 32'h1234_5678, 0), nojob);
        run_round(1, 0, mk_job(32'h140, 32'h0, 4'h0, TO - 1, 32'hCAFE_F00D, 0), nojob);
        run_round(0, 1, nojob, mk_job(32'h180, 32'hA5A5_A5A5, 4'hF, 1000, 32'h0, 0));

        for (int n = 0; n < 60; n++) begin
            sel = 2'($urandom_range(1, 3));
            j0 = rnd_job();
            j1 = rnd_job();
            if (sel == 2'b11 && $urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 1) == 1) j0.start = 1;
                else j1.start = 1;
            end
            run_round(sel[0], sel[1], j0, j1);
        end

        // Leave the pointer favouring m1, then reset in the middle of an m1 transaction.
        run_round(1, 0, mk_job(32'h1A0, 32'h0, 4'h0, 2, 32'h7777_7777, 0), nojob);
        @(negedge clk);
        j1 = mk_job(32'h1C0, 32'h0000_0001, 4'h1, 1000, 32'h0, 0);
        gq.push_back('{grant: 2'b10, addr: j1.addr, wdata: j1.wdata, wstrb: j1.wstrb});
        sp.push_back('{d: 1000, data: 32'h0});
        q1.push_back(j1);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (grant != 2'b00);
        end
        chk("pre_reset_busy", 64'(seen), 64'(1));
        repeat (3) @(negedge clk);
        chk("pre_reset_s_valid", 64'(s_valid), 64'(1));
        @(posedge clk); #1;
        rst = 1;
        eq0.delete(); eq1.delete(); gq.delete(); sp.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk("midrst_grant", 64'(grant), 64'(2'b00));
        chk("midrst_s_valid", 64'(s_valid), 64'(0));
        chk("midrst_m1_ready", 64'(m1_ready), 64'(0));
        chk("midrst_m1_rdata", 64'(m1_rdata), 64'(0));
        chk("midrst_timeout_err", 64'(timeout_err), 64'(0));
        @(posedge clk); #1;
        rst = 0;
        slave_late = 1;
        repeat (3) begin @(posedge clk); #1; end
        slave_late = 0;
        ptr = 0;
        wait_idle();

        run_round(1, 1, mk_job(32'h400, 32'h0, 4'h0, 1, 32'h8888_0000, 0),
                        mk_job(32'h500, 32'h9999_9999, 4'h5, 0, 32'h9999_0000, 0));
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
